clock_fir_top: RTL and testbench
================================

// Module: clock_fir_top
// PURPOSE
//   Top-level of the demo board: a 24-hour time-of-day clock (loadable HH:MM)
//   and an 8-bit 4-tap FIR smoothing two byte inputs, both shown on seven-segment
//   digits (HH:MM on four digits, FIR result as three decimal digits) plus four status LEDs.
// PARAMETERS
//   CLK_PER_SEC  50_000_000  clk cycles per second tick (override small in simulation)
// PORTS
//   clk                 in   1  system clock (50 MHz nominal)
//   rst_n               in   1  asynchronous active-low reset
//   initial_time_hh     in   5  hour to load, 0..23
//   initial_time_mm     in   6  minute to load, 0..59
//   initial_time_valid  in   1  one-cycle load strobe for hh/mm
//   PEbar               in   1  FIR process enable: 1 = run, 0 = clear
//   data_1              in   8  FIR input A (unsigned)
//   data_2              in   8  FIR input B (unsigned)
//   out                 out  8  registered FIR result
//   h1_7,h0_7           out  7  hour tens / ones segments
//   m1_7,m0_7           out  7  minute tens / ones segments
//   FIR_out2_7/1_7/0_7  out  7  hundreds / tens / ones of out
//   ap                  out  4  status LEDs
// BEHAVIOUR
//   Reset (async, rst_n=0): time 00:00:00, prescaler 0, FIR taps/out 0, ap=0;
//     segment outputs therefore show "0" (7'h3F).
//   Time: prescaler counts 0..CLK_PER_SEC-1; at terminal count sec++.
//     sec 59->0 carries mm; mm 59->0 carries hh; hh 23->0 (23:59:59 -> 00:00:00).
//   Load: initial_time_valid=1 at a clk edge with hh<=23 and mm<=59 sets hh/mm,
//     sec=0, prescaler=0; load beats a same-cycle tick. Out-of-range values: strobe ignored.
//   FIR: x = (data_1 + data_2) >> 1, 9-bit sum, result 8-bit.
//     Delay line d0,d1,d2. Each edge with PEbar=1:
//     out <= (x + 3*d0 + 3*d1 + d2) >> 3 (11-bit internal sum, no overflow);
//     d0<=x, d1<=d0, d2<=d1. Coeffs 1,3,3,1 (DC gain 1).
//   PEbar=0 at an edge: d0..d2 and out synchronously cleared to 0.
//   Latency: first out one edge after x is sampled; constant input settles after 4 edges.
//   Decimal split: hundreds = out/100, tens = (out/10)%10, ones = out%10 (combinational).
//   Seven-seg encoding, active-high, bit0=a..bit6=g:
//     0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; any other code -> 7'h00.
//   Hour/minute digits: tens = value/10, ones = value%10.
//   ap[0] PM flag = (hh >= 12).
//   ap[1] colon, toggles on every second tick.
//   ap[2] FIR valid: 1 once 4 consecutive PEbar=1 edges occurred; cleared by PEbar=0.
//   ap[3] time-set: 1 after first accepted load, held until reset.
//   All state in clk domain; segment outputs are combinational from registers.
// TESTING
//   1 Reset asserted -> out=0, all digit outputs 7'h3F, ap=4'b0000.
//   2 Load 12:35 with valid pulse -> h1/h0/m1/m0 = 06,5B,4F,6D; ap[0]=1, ap[3]=1.
//   3 PEbar=1, data_1=77, data_2=66 (x=71) -> out 8,35,62,71 on successive edges;
//     then FIR digits 3F/07/06 ("071"), ap[2]=1.
//   4 CLK_PER_SEC=4, load 23:59, run 60 s -> 00:00, ap[0]=0; ap[1] toggled each second.
//   5 Load hh=24 or mm=60 -> time unchanged; PEbar=0 mid-run -> out=0 next edge, ap[2]=0.
//   6 data_1=data_2=255 steady -> out=255, digits 5B/6D/6D; rst_n low mid-count -> all reset at once.

Source files
------------

// File: rtl/clock_fir_top.sv
`default_nettype none
// ============================================================================
// Module   : clock_fir_top
// Purpose  : 24-hour loadable HH:MM clock plus a 1-3-3-1 byte FIR smoother,
//            both decoded onto seven-segment digits, with four status LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module clock_fir_top #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] initial_time_hh,
    input  logic [5:0] initial_time_mm,
    input  logic       initial_time_valid,
    input  logic       PEbar,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    output logic [7:0] out,
    output logic [6:0] h1_7,
    output logic [6:0] h0_7,
    output logic [6:0] m1_7,
    output logic [6:0] m0_7,
    output logic [6:0] FIR_out2_7,
    output logic [6:0] FIR_out1_7,
    output logic [6:0] FIR_out0_7,
    output logic [3:0] ap
);

    localparam int             CNT_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       mm_q, mm_d;
    logic [4:0]       hh_q, hh_d;
    logic             colon_q, colon_d;
    logic             set_q, set_d;

    logic [7:0]       d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic [7:0]       out_q, out_d;
    logic [2:0]       vcnt_q, vcnt_d;

    logic             tick;
    logic             load_ok;
    logic [8:0]       pair_sum;
    logic [7:0]       x;
    logic [10:0]      acc;

    // ------------------------------------------------------------------
    // Time of day
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        mm_d    = mm_q;
        hh_d    = hh_q;
        colon_d = colon_q;
        set_d   = set_q;
        tick    = (presc_q == TERM_CNT);
        load_ok = initial_time_valid && (initial_time_hh <= 5'd23) && (initial_time_mm <= 6'd59);

        // A valid load swallows a coincident second tick entirely.
        if (load_ok) begin
            hh_d    = initial_time_hh;
            mm_d    = initial_time_mm;
            sec_d   = '0;
            presc_d = '0;
            set_d   = 1'b1;
        end else if (tick) begin
            presc_d = '0;
            colon_d = ~colon_q;
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (mm_q == 6'd59) begin
                    mm_d = '0;
                    hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                end else begin
                    mm_d = mm_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIR: taps 1,3,3,1 over the averaged input pair, >>3 for unity DC gain
    // ------------------------------------------------------------------
    always_comb begin
        pair_sum = {1'b0, data_1} + {1'b0, data_2};
        x        = 8'(pair_sum >> 1);
        acc      = {3'b0, x} + 11'd3 * {3'b0, d0_q} + 11'd3 * {3'b0, d1_q} + {3'b0, d2_q};

        d0_d   = '0;
        d1_d   = '0;
        d2_d   = '0;
        out_d  = '0;
        vcnt_d = '0;
        if (PEbar) begin
            d0_d   = x;
            d1_d   = d0_q;
            d2_d   = d1_q;
            out_d  = 8'(acc >> 3);
            vcnt_d = (vcnt_q == 3'd4) ? 3'd4 : vcnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= '0;
            mm_q    <= '0;
            hh_q    <= '0;
            colon_q <= 1'b0;
            set_q   <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            out_q   <= '0;
            vcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            mm_q    <= mm_d;
            hh_q    <= hh_d;
            colon_q <= colon_d;
            set_q   <= set_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            out_q   <= out_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Display decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [7:0] d);
        case (d)
            8'd0:    seg7 = 7'h3F;
            8'd1:    seg7 = 7'h06;
            8'd2:    seg7 = 7'h5B;
            8'd3:    seg7 = 7'h4F;
            8'd4:    seg7 = 7'h66;
            8'd5:    seg7 = 7'h6D;
            8'd6:    seg7 = 7'h7D;
            8'd7:    seg7 = 7'h07;
            8'd8:    seg7 = 7'h7F;
            8'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic [7:0] hh8, mm8;

    always_comb begin
        hh8        = {3'b0, hh_q};
        mm8        = {2'b0, mm_q};
        h1_7       = seg7(hh8 / 8'd10);
        h0_7       = seg7(hh8 % 8'd10);
        m1_7       = seg7(mm8 / 8'd10);
        m0_7       = seg7(mm8 % 8'd10);
        FIR_out2_7 = seg7(out_q / 8'd100);
        FIR_out1_7 = seg7((out_q / 8'd10) % 8'd10);
        FIR_out0_7 = seg7(out_q % 8'd10);
        out        = out_q;
        ap         = {set_q, (vcnt_q == 3'd4), colon_q, (hh_q >= 5'd12)};
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_fir_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_fir_top
// Purpose  : Directed self-checking bench for clock_fir_top (CLK_PER_SEC = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_fir_top;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S5 = 7'h6D,
                           S6 = 7'h7D, S7 = 7'h07, S9 = 7'h6F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] initial_time_hh;
    logic [5:0] initial_time_mm;
    logic       initial_time_valid;
    logic       PEbar;
    logic [7:0] data_1, data_2;
    logic [7:0] out;
    logic [6:0] h1_7, h0_7, m1_7, m0_7, FIR_out2_7, FIR_out1_7, FIR_out0_7;
    logic [3:0] ap;

    int n_checks = 0;
    int n_fail   = 0;

    clock_fir_top #(.CLK_PER_SEC(4)) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .initial_time_hh    (initial_time_hh),
        .initial_time_mm    (initial_time_mm),
        .initial_time_valid (initial_time_valid),
        .PEbar              (PEbar),
        .data_1             (data_1),
        .data_2             (data_2),
        .out                (out),
        .h1_7               (h1_7),
        .h0_7               (h0_7),
        .m1_7               (m1_7),
        .m0_7               (m0_7),
        .FIR_out2_7         (FIR_out2_7),
        .FIR_out1_7         (FIR_out1_7),
        .FIR_out0_7         (FIR_out0_7),
        .ap                 (ap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input logic [6:0] eh1, input logic [6:0] eh0,
                              input logic [6:0] em1, input logic [6:0] em0);
        check({tag, "_h1"}, 32'(h1_7), 32'(eh1));
        check({tag, "_h0"}, 32'(h0_7), 32'(eh0));
        check({tag, "_m1"}, 32'(m1_7), 32'(em1));
        check({tag, "_m0"}, 32'(m0_7), 32'(em0));
    endtask

    task automatic check_fir_digits(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                                    input logic [6:0] e0);
        check({tag, "_d2"}, 32'(FIR_out2_7), 32'(e2));
        check({tag, "_d1"}, 32'(FIR_out1_7), 32'(e1));
        check({tag, "_d0"}, 32'(FIR_out0_7), 32'(e0));
    endtask

    task automatic load_time(input logic [4:0] hh, input logic [5:0] mm);
        initial_time_hh    = hh;
        initial_time_mm    = mm;
        initial_time_valid = 1'b1;
        step(1);
        initial_time_valid = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        initial_time_hh    = '0;
        initial_time_mm    = '0;
        initial_time_valid = 1'b0;
        PEbar              = 1'b0;
        data_1             = '0;
        data_2             = '0;
        step(2);

        check("rst_out", 32'(out), 0);
        check_time("rst", S0, S0, S0, S0);
        check_fir_digits("rst_fir", S0, S0, S0);
        check("rst_ap", 32'(ap), 0);

        rst_n = 1'b1;
        step(1);

        load_time(5'd12, 6'd35);
        check_time("load1235", S1, S2, S3, S5);
        check("load_pm", 32'(ap[0]), 1);
        check("load_set", 32'(ap[3]), 1);

        load_time(5'd24, 6'd0);
        check_time("rej_hh24", S1, S2, S3, S5);
        load_time(5'd5, 6'd60);
        check_time("rej_mm60", S1, S2, S3, S5);
        check("rej_set", 32'(ap[3]), 1);

        // x = (77+66)>>1 = 71; outputs ramp 8, 35, 62, 71
        PEbar  = 1'b1;
        data_1 = 8'd77;
        data_2 = 8'd66;
        step(1); check("fir71_e1", 32'(out), 8);  check("fir71_v1", 32'(ap[2]), 0);
        step(1); check("fir71_e2", 32'(out), 35);
        step(1); check("fir71_e3", 32'(out), 62); check("fir71_v3", 32'(ap[2]), 0);
        step(1); check("fir71_e4", 32'(out), 71); check("fir71_v4", 32'(ap[2]), 1);
        check_fir_digits("fir71", S0, S7, S1);

        PEbar = 1'b0;
        step(1);
        check("clr_out", 32'(out), 0);
        check("clr_valid", 32'(ap[2]), 0);

        // x = 255; ramp 31, 127, 223, 255
        data_1 = 8'd255;
        data_2 = 8'd255;
        PEbar  = 1'b1;
        step(1); check("fir255_e1", 32'(out), 31);
        step(1); check("fir255_e2", 32'(out), 127);
        PEbar = 1'b0;
        step(1); check("midclr_out", 32'(out), 0); check("midclr_valid", 32'(ap[2]), 0);
        PEbar = 1'b1;
        step(3); check("fir255_e3", 32'(out), 223); check("fir255_v3", 32'(ap[2]), 0);
        step(1); check("fir255_e4", 32'(out), 255); check("fir255_v4", 32'(ap[2]), 1);
        check_fir_digits("fir255", S2, S5, S5);

        // Asynchronous reset between clock edges
        rst_n = 1'b0;
        #1;
        check("arst_out", 32'(out), 0);
        check_time("arst", S0, S0, S0, S0);
        check_fir_digits("arst_fir", S0, S0, S0);
        check("arst_ap", 32'(ap), 0);
        PEbar = 1'b0;
        step(2);
        check("arst_hold_out", 32'(out), 0);

        rst_n = 1'b1;
        load_time(5'd23, 6'd59);
        check_time("load2359", S2, S3, S5, S9);
        check("load2359_ap", 32'(ap), 32'(4'b1001));

        for (int k = 1; k <= 60; k++) begin
            step(4);
            check($sformatf("colon_s%0d", k), 32'(ap[1]), 32'(k % 2));
            if (k == 59) check_time("t235959", S2, S3, S5, S9);
        end
        check_time("wrap0000", S0, S0, S0, S0);
        check("wrap_pm", 32'(ap[0]), 0);
        check("wrap_set", 32'(ap[3]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
